// File: rtl/mem_ctrl.sv
// Byte-serial arbiter letting an instruction-fetch port and a load/store port
// share one 8-bit synchronous RAM. Load/store has priority over fetch.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              ram_wr,
    output logic              busy
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic              busy_q, busy_d;
    logic [1:0]        rd_idx;
    logic [1:0]        wr_idx;

    // ram_a/ram_dout/ram_wr are registered one step ahead so that they carry
    // addr+cnt and wdata byte cnt during the cycle in which cnt has that value.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        addr_d      = addr_q;
        owner_d     = owner_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        rd_idx      = 2'(cnt_q - 3'd1);
        wr_idx      = 2'(cnt_q + 3'd1);

        case (state_q)
            IDLE: begin
                if (mem_req && !mem_done_q) begin
                    owner_d = OWN_MEM;
                    addr_d  = mem_addr;
                    ram_a_d = mem_addr;
                    cnt_d   = '0;
                    case (mem_len)
                        2'b00:   len_d = 3'd1;
                        2'b01:   len_d = 3'd2;
                        default: len_d = 3'd4;
                    endcase
                    if (mem_we) begin
                        state_d    = WRITE;
                        ram_dout_d = mem_wdata[7:0];
                        ram_wr_d   = 1'b1;
                    end else begin
                        state_d     = READ;
                        mem_rdata_d = '0;
                    end
                end else if (if_req && !if_done_q) begin
                    owner_d = OWN_IF;
                    addr_d  = if_addr;
                    ram_a_d = if_addr;
                    cnt_d   = '0;
                    len_d   = 3'd4;
                    state_d = READ;
                end
            end
            READ: begin
                // ram_din holds the byte addressed in the previous cycle
                if (cnt_q != '0) begin
                    if (owner_q == OWN_IF) if_data_d[8*rd_idx +: 8]   = ram_din;
                    else                   mem_rdata_d[8*rd_idx +: 8] = ram_din;
                end
                if (cnt_q == len_q) begin
                    state_d = IDLE;
                    if (owner_q == OWN_IF) if_done_d  = 1'b1;
                    else                   mem_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_d < len_q) ram_a_d = addr_q + ADDR_W'(cnt_d);
                end
            end
            WRITE: begin
                if (cnt_q == len_q - 3'd1) begin
                    state_d    = IDLE;
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 3'd1;
                    ram_a_d    = addr_q + ADDR_W'(cnt_d);
                    ram_dout_d = mem_wdata[8*wr_idx +: 8];
                    ram_wr_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            owner_q     <= OWN_IF;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            owner_q     <= owner_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            busy_q      <= busy_d;
        end
    end

    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign ram_wr    = ram_wr_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide synchronous RAM model whose
// untouched locations return fixed preload contents.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        ram_wr;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    int wr_cnt = 0;

    bit [7:0] mem [bit [31:0]];

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din), .ram_wr(ram_wr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic bit [7:0] ram_rd(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        case (a)
            32'h0000_0100: return 8'h11;
            32'h0000_0101: return 8'h22;
            32'h0000_0102: return 8'h33;
            32'h0000_0103: return 8'h44;
            32'h0000_0300: return 8'h5A;
            32'h0000_0301: return 8'hA5;
            32'hFFFF_FFFE: return 8'h01;
            32'hFFFF_FFFF: return 8'h02;
            32'h0000_0000: return 8'h03;
            32'h0000_0001: return 8'h04;
            default:       return 8'h00;
        endcase
    endfunction

    // Synchronous RAM: data for the address seen at an edge appears after it
    always @(posedge clk) begin
        if (ram_wr === 1'b1) begin
            mem[ram_a] = ram_dout;
            wr_cnt     = wr_cnt + 1;
        end
        ram_din <= ram_rd(ram_a);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic wait_done(input bit is_if, input int maxc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (((is_if ? if_done : mem_done) !== 1'b1) && n < maxc);
    endtask

    initial begin
        int n;
        int base;
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_len = 2'b00; mem_wdata = '0;

        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_ram_a", ram_a, 32'h0);
        chk("rst_ram_dout", 32'(ram_dout), 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
        tick(); tick();
        rst = 1'b1;

        // Word fetch from 0x100
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("fetch_busy", 32'(busy), 32'd1);
        chk("fetch_ram_a0", ram_a, 32'h100);
        chk("fetch_ram_wr", 32'(ram_wr), 32'd0);
        wait_done(1'b1, 8, n);
        chk("fetch_latency", n, 5);
        chk("fetch_data", if_data, 32'h4433_2211);
        chk("fetch_ram_a_hold", ram_a, 32'h103);

        // if_req held through if_done: no grant on done edge, grant one later
        tick();
        chk("fetch_no_regrant", 32'(busy), 32'd0);
        tick();
        chk("fetch_regrant", 32'(busy), 32'd1);
        wait_done(1'b1, 8, n);
        chk("fetch2_latency", n, 5);
        chk("fetch2_data", if_data, 32'h4433_2211);
        if_req = 1'b0;

        // Byte store
        base = wr_cnt;
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b00; mem_addr = 32'h200; mem_wdata = 32'hAABB_CCDD;
        tick();
        chk("st1_ram_wr", 32'(ram_wr), 32'd1);
        chk("st1_ram_a", ram_a, 32'h200);
        chk("st1_ram_dout", 32'(ram_dout), 32'hDD);
        chk("st1_no_done", 32'(mem_done), 32'd0);
        tick();
        chk("st1_wr_off", 32'(ram_wr), 32'd0);
        chk("st1_done", 32'(mem_done), 32'd1);
        mem_req = 1'b0;
        chk("st1_wr_count", wr_cnt - base, 1);
        chk("st1_ram_200", 32'(ram_rd(32'h200)), 32'hDD);
        chk("st1_ram_201", 32'(ram_rd(32'h201)), 32'h00);
        tick();

        // Simultaneous requests: load has priority
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b01; mem_addr = 32'h300;
        tick();
        chk("prio_busy", 32'(busy), 32'd1);
        chk("prio_ram_a", ram_a, 32'h300);
        wait_done(1'b0, 8, n);
        chk("ld2_latency", n, 3);
        chk("ld2_data", mem_rdata, 32'h0000_A55A);
        chk("ld2_if_idle", 32'(if_done), 32'd0);
        mem_req = 1'b0;
        tick();
        chk("prio_if_grant", 32'(busy), 32'd1);
        chk("prio_if_ram_a", ram_a, 32'h100);
        wait_done(1'b1, 8, n);
        chk("prio_if_latency", n, 5);
        chk("prio_if_data", if_data, 32'h4433_2211);
        if_req = 1'b0;

        // Byte load clears upper bytes at grant
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h101;
        tick();
        chk("ld1_cleared", mem_rdata, 32'h0);
        wait_done(1'b0, 8, n);
        chk("ld1_latency", n, 2);
        chk("ld1_data", mem_rdata, 32'h0000_0022);
        mem_req = 1'b0;
        tick();

        // Word load (len 11) wrapping past the top of the address space
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b11; mem_addr = 32'hFFFF_FFFE;
        tick();
        chk("wrap_a0", ram_a, 32'hFFFF_FFFE);
        tick();
        chk("wrap_a1", ram_a, 32'hFFFF_FFFF);
        tick();
        chk("wrap_a2", ram_a, 32'h0000_0000);
        tick();
        chk("wrap_a3", ram_a, 32'h0000_0001);
        wait_done(1'b0, 8, n);
        chk("wrap_latency", n, 2);
        chk("wrap_data", mem_rdata, 32'h0403_0201);
        mem_req = 1'b0;
        tick();

        // Reset in the second cycle of a word store
        base = wr_cnt;
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h400; mem_wdata = 32'h8765_4321;
        tick();
        chk("abort_c1_wr", 32'(ram_wr), 32'd1);
        chk("abort_c1_dout", 32'(ram_dout), 32'h21);
        tick();
        chk("abort_c2_a", ram_a, 32'h401);
        chk("abort_c2_wr", 32'(ram_wr), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_wr_off", 32'(ram_wr), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ram_a", ram_a, 32'h0);
        mem_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("abort_no_done", 32'(mem_done), 32'd0);
        tick();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_wr_count", wr_cnt - base, 1);
        chk("abort_ram_400", 32'(ram_rd(32'h400)), 32'h21);
        chk("abort_ram_401", 32'(ram_rd(32'h401)), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
